// File: rtl/fet_gate_driver_pkg.sv
// Shared types and constants for the FET gate driver dead-time stage.
package fet_gate_pkg;

  localparam int CHANNELS = 4;
  localparam int DT_WIDTH = 8;

  // Per-channel gate sequencing state. The 2-bit encoding is also exported
  // on the debug state bus.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    HI_ON = 2'd2,
    LO_ON = 2'd3
  } state_t;

  // Dead-time counter load value. A programmed dead-time of zero still
  // gives one both-off cycle, so the counter is never loaded with 0.
  function automatic logic [DT_WIDTH-1:0] dt_load(input logic [DT_WIDTH-1:0] dt);
    return (dt == '0) ? DT_WIDTH'(1) : dt;
  endfunction

endpackage

// File: rtl/fet_gate_driver_if.sv
// Control and status bundle between the PWM/software side and the gate driver.
// There is no valid/ready handshake on this bundle. Every signal is a level
// sampled on each rising clock edge. fault_clr is a one-cycle pulse that is
// acted on in the cycle it is high.
interface fet_gate_driver_if;

  logic [fet_gate_pkg::CHANNELS-1:0]   pwm_in;
  logic [fet_gate_pkg::CHANNELS-1:0]   enable;
  logic [fet_gate_pkg::DT_WIDTH-1:0]   deadtime;
  logic                                fault_clr;
  logic [fet_gate_pkg::CHANNELS-1:0]   gate_hi;
  logic [fet_gate_pkg::CHANNELS-1:0]   gate_lo;
  logic                                fault_latched;
  logic [fet_gate_pkg::CHANNELS-1:0]   ch_dead;
  // Two bits per channel, channel g at [2g+1:2g], encoded as state_t.
  logic [2*fet_gate_pkg::CHANNELS-1:0] dbg_state;

  modport master (
    output pwm_in, enable, deadtime, fault_clr,
    input  gate_hi, gate_lo, fault_latched, ch_dead, dbg_state
  );

  modport slave (
    input  pwm_in, enable, deadtime, fault_clr,
    output gate_hi, gate_lo, fault_latched, ch_dead, dbg_state
  );

endinterface

// File: rtl/fet_gate_driver_channel.sv
// One half-bridge channel: a dead-time FSM with a down counter and a target
// register. Gate outputs are registered from the next state, so they never
// glitch and can never both be high.
module fet_gate_channel
  import fet_gate_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_pwm,
  input  logic                i_enable,
  input  logic                i_fault,
  input  logic [DT_WIDTH-1:0] i_deadtime,
  output logic                o_gate_hi,
  output logic                o_gate_lo,
  output logic                o_dead,
  output state_t              o_state
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DT_WIDTH-1:0] r_cnt;
  logic [DT_WIDTH-1:0] w_cnt_nxt;
  logic                r_target;
  logic                w_target_nxt;
  logic                r_gate_hi;
  logic                r_gate_lo;
  logic                r_dead;

  // Next-state decode. The disable/fault path overrides everything. The
  // counter is only loaded on DEAD entry, so deadtime changes inside DEAD
  // are ignored.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    if (!i_enable || i_fault) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt  = DEAD;
          w_target_nxt = i_pwm;
          w_cnt_nxt    = dt_load(i_deadtime);
        end
        HI_ON: begin
          if (!i_pwm) begin
            w_state_nxt  = DEAD;
            w_target_nxt = 1'b0;
            w_cnt_nxt    = dt_load(i_deadtime);
          end
        end
        LO_ON: begin
          if (i_pwm) begin
            w_state_nxt  = DEAD;
            w_target_nxt = 1'b1;
            w_cnt_nxt    = dt_load(i_deadtime);
          end
        end
        DEAD: begin
          w_target_nxt = i_pwm;
          // Leaving at 1 means the counter never reaches 0 or wraps.
          // The <= guard only matters if the counter were ever corrupted.
          if (r_cnt <= DT_WIDTH'(1)) begin
            w_state_nxt = r_target ? HI_ON : LO_ON;
          end else begin
            w_cnt_nxt = r_cnt - DT_WIDTH'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, counter, target and output registers. Reset drops the gates at
  // once, with no dead-time sequencing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_target  <= 1'b0;
      r_gate_hi <= 1'b0;
      r_gate_lo <= 1'b0;
      r_dead    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_target  <= w_target_nxt;
      r_gate_hi <= (w_state_nxt == HI_ON);
      r_gate_lo <= (w_state_nxt == LO_ON);
      r_dead    <= (w_state_nxt == DEAD);
    end
  end

  assign o_gate_hi = r_gate_hi;
  assign o_gate_lo = r_gate_lo;
  assign o_dead    = r_dead;
  assign o_state   = r_state;

endmodule

// File: rtl/fet_gate_driver.sv
// Quad dead-time / shoot-through protection stage. This top level holds the
// fault pin synchroniser, the sticky fault latch and one FSM per channel.
module fet_gate_driver
  import fet_gate_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              fault_in,
  fet_gate_driver_if.slave  bus
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_fault;
  logic [CHANNELS-1:0]   w_gate_hi;
  logic [CHANNELS-1:0]   w_gate_lo;
  logic [CHANNELS-1:0]   w_dead;
  logic [2*CHANNELS-1:0] w_dbg_state;

  // Two-flop synchroniser for the asynchronous fault pin.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= fault_in;
      r_sync2 <= r_sync1;
    end
  end

  // Sticky fault latch. A synchronised fault wins over a clear in the same
  // cycle, so the latch cannot be cleared while the pin is still high.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_fault <= 1'b0;
    end else if (r_sync2) begin
      r_fault <= 1'b1;
    end else if (bus.fault_clr) begin
      r_fault <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t w_state;

    fet_gate_channel u_ch (
      .i_clk      (wb_clk_i),
      .i_rst_n    (wb_rst_ni),
      .i_pwm      (bus.pwm_in[g]),
      .i_enable   (bus.enable[g]),
      .i_fault    (r_fault),
      .i_deadtime (bus.deadtime),
      .o_gate_hi  (w_gate_hi[g]),
      .o_gate_lo  (w_gate_lo[g]),
      .o_dead     (w_dead[g]),
      .o_state    (w_state)
    );

    assign w_dbg_state[2*g +: 2] = w_state;
  end

  assign bus.gate_hi       = w_gate_hi;
  assign bus.gate_lo       = w_gate_lo;
  assign bus.ch_dead       = w_dead;
  assign bus.fault_latched = r_fault;
  assign bus.dbg_state     = w_dbg_state;

endmodule

// File: tb/tb_fet_gate_driver.sv
// Directed bench for fet_gate_driver. The driver sets the inputs on the
// falling edge. After each rising edge it queues the hand-computed output
// word. A monitor on the falling edge pops that word and compares it.
module tb_fet_gate_driver;

  localparam int NC = fet_gate_pkg::CHANNELS;
  localparam int EW = 3*NC + 1;

  logic clk;
  logic rst_n;
  logic fault_in;

  fet_gate_driver_if bus();

  fet_gate_driver dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .fault_in  (fault_in),
    .bus       (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state. Each word is packed as {gate_hi, gate_lo, ch_dead, fault_latched}.
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int word_idx = 0;

  // Monitor: checks the overlap invariant and compares against queued words.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp_w;
    act = {bus.gate_hi, bus.gate_lo, bus.ch_dead, bus.fault_latched};
    checks++;
    if ((bus.gate_hi & bus.gate_lo) != '0) begin
      failures++;
      $display("FAIL overlap t=%0t gate_hi=%b gate_lo=%b required no common bit",
               $time, bus.gate_hi, bus.gate_lo);
    end
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (act !== exp_w) begin
        failures++;
        $display("FAIL word%0d t=%0t hi/lo/dead/flt got=%b_%b_%b_%b want=%b_%b_%b_%b",
                 word_idx, $time,
                 act[EW-1 -: NC], act[EW-1-NC -: NC], act[NC:1], act[0],
                 exp_w[EW-1 -: NC], exp_w[EW-1-NC -: NC], exp_w[NC:1], exp_w[0]);
      end
      word_idx++;
    end
  end

  // Driver: one clock, then queue the outputs expected after that edge.
  task automatic tick(input logic [NC-1:0] hi, input logic [NC-1:0] lo,
                      input logic [NC-1:0] dead, input logic flt);
    @(posedge clk);
    exp_q.push_back({hi, lo, dead, flt});
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [NC-1:0] hi, input logic [NC-1:0] lo,
                     input logic [NC-1:0] dead, input logic flt);
    for (int i = 0; i < n; i++) tick(hi, lo, dead, flt);
  endtask

  // Immediate check used for the asynchronous reset response.
  task automatic check_now(input string name, input logic [EW-1:0] want);
    logic [EW-1:0] act;
    act = {bus.gate_hi, bus.gate_lo, bus.ch_dead, bus.fault_latched};
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, want);
    end
  endtask

  initial begin
    int guard;
    rst_n         = 1'b1;
    fault_in      = 1'b0;
    bus.pwm_in    = '0;
    bus.enable    = '0;
    bus.deadtime  = '0;
    bus.fault_clr = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);

    // Reset state.
    run(2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    run(2, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // ch0 start-up, deadtime 5: five dead cycles, then the low side turns on.
    bus.deadtime = 8'd5;
    bus.enable   = 4'b0001;
    run(5, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    run(3, 4'b0000, 4'b0001, 4'b0000, 1'b0);

    // ch1, deadtime 3: start-up, then a 0->1 and a 1->0 toggle.
    bus.enable   = 4'b0011;
    bus.deadtime = 8'd3;
    run(3, 4'b0000, 4'b0001, 4'b0010, 1'b0);
    run(2, 4'b0000, 4'b0011, 4'b0000, 1'b0);
    bus.pwm_in = 4'b0010;
    run(3, 4'b0000, 4'b0001, 4'b0010, 1'b0);
    run(2, 4'b0010, 4'b0001, 4'b0000, 1'b0);
    bus.pwm_in = 4'b0000;
    run(3, 4'b0000, 4'b0001, 4'b0010, 1'b0);
    run(2, 4'b0000, 4'b0011, 4'b0000, 1'b0);

    // ch2, deadtime 0: exactly one both-off cycle per transition.
    bus.deadtime = 8'd0;
    bus.enable   = 4'b0111;
    tick(4'b0000, 4'b0011, 4'b0100, 1'b0);
    run(3, 4'b0000, 4'b0111, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      bus.pwm_in = 4'b0100;
      tick(4'b0000, 4'b0011, 4'b0100, 1'b0);
      run(3, 4'b0100, 4'b0011, 4'b0000, 1'b0);
      bus.pwm_in = 4'b0000;
      tick(4'b0000, 4'b0011, 4'b0100, 1'b0);
      run(3, 4'b0000, 4'b0111, 4'b0000, 1'b0);
    end

    // ch2, deadtime 10: a 2-cycle pulse from LO_ON is swallowed.
    // The deadtime change in the middle of DEAD has no effect.
    bus.deadtime = 8'd10;
    bus.pwm_in   = 4'b0100;
    run(2, 4'b0000, 4'b0011, 4'b0100, 1'b0);
    bus.pwm_in   = 4'b0000;
    run(2, 4'b0000, 4'b0011, 4'b0100, 1'b0);
    bus.deadtime = 8'd2;
    run(6, 4'b0000, 4'b0011, 4'b0100, 1'b0);
    run(2, 4'b0000, 4'b0111, 4'b0000, 1'b0);

    // Enable drop on ch2 turns its gate off after the same edge.
    bus.enable = 4'b0011;
    tick(4'b0000, 4'b0011, 4'b0000, 1'b0);

    // All four channels run, deadtime 3.
    bus.deadtime = 8'd3;
    bus.pwm_in   = 4'b1010;
    bus.enable   = 4'b1111;
    run(3, 4'b0000, 4'b0001, 4'b1110, 1'b0);
    run(2, 4'b1010, 4'b0101, 4'b0000, 1'b0);

    // Fault: latch on the third edge, gates off on the fourth.
    fault_in = 1'b1;
    run(2, 4'b1010, 4'b0101, 4'b0000, 1'b0);
    tick(4'b1010, 4'b0101, 4'b0000, 1'b1);
    run(2, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    // A clear while the pin is still high is ignored.
    bus.fault_clr = 1'b1;
    tick(4'b0000, 4'b0000, 4'b0000, 1'b1);
    bus.fault_clr = 1'b0;
    fault_in      = 1'b0;
    run(3, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    // A clear after the synchroniser drains works; the restart goes through DEAD.
    bus.fault_clr = 1'b1;
    tick(4'b0000, 4'b0000, 4'b0000, 1'b0);
    bus.fault_clr = 1'b0;
    run(3, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    run(2, 4'b1010, 4'b0101, 4'b0000, 1'b0);

    // Asynchronous reset while ch3 is in HI_ON.
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", '0);
    run(2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    bus.enable = 4'b0000;
    rst_n      = 1'b1;
    run(3, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    bus.pwm_in   = 4'b0000;
    bus.deadtime = 8'd1;
    bus.enable   = 4'b0001;
    tick(4'b0000, 4'b0000, 4'b0001, 1'b0);
    run(2, 4'b0000, 4'b0001, 4'b0000, 1'b0);

    // Wait, with a bound, for the monitor to empty the queue.
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain queue_left=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fet_gate_driver.md
# fet_gate_driver

Per-channel dead-time and shoot-through protection stage sitting directly downstream of the quad PWM FET driver core. It takes one logic-level PWM bit per channel and produces a complementary high-side/low-side gate pair. A configurable dead-time is inserted on every transition, and the two gates of one channel are never on together. An external fault pin, synchronised and latched, forces every gate off until software clears it.

## Interface
- CHANNELS, 4: number of half-bridge channels
- DT_WIDTH, 8: width of dead-time count, in clock cycles

- wb_clk_i  input  1  system clock; everything is in this domain except fault_in
- wb_rst_ni  input  1  reset, asynchronous assert, active-low
- pwm_in  input  CHANNELS  PWM level per channel from the PWM core, same clock domain, no synchroniser
- enable  input  CHANNELS  per-channel run enable; 0 forces the channel off
- deadtime  input  DT_WIDTH  dead-time in cycles, shared by all channels
- fault_in  input  1  asynchronous external fault pin, active-high
- fault_clr  input  1  single-cycle clear request for the fault latch
- gate_hi  output  CHANNELS  high-side gate drive, registered
- gate_lo  output  CHANNELS  low-side gate drive, registered
- fault_latched  output  1  sticky fault flag, registered
- ch_dead  output  CHANNELS  1 while a channel is in dead-time, for status and debug

## Operation
- Each channel runs an FSM with states IDLE, DEAD, HI_ON and LO_ON.
- Outputs decode from the registered state:
  - gate_hi = (state == HI_ON)
  - gate_lo = (state == LO_ON)
  - ch_dead = (state == DEAD)
  - By construction, gate_hi and gate_lo of one channel are never both 1.
- IDLE:
  - Exits when enable=1 and fault_latched=0.
  - Goes to DEAD with target = pwm_in and the counter loaded.
- HI_ON: pwm_in=0 → DEAD, target LO, counter loaded.
- LO_ON: pwm_in=1 → DEAD, target HI, counter loaded.
- DEAD:
  - The counter decrements every cycle.
  - The target is updated every cycle from pwm_in.
  - The counter is never reloaded while in DEAD.
  - When counter==1: go to HI_ON if the target is 1, else LO_ON.
- Counter load value = max(deadtime, 1). deadtime=0 therefore still gives one both-off cycle.
- deadtime is sampled only at DEAD entry. A change mid-dead-time has no effect until the next entry.
- From any state, enable=0 or fault_latched=1 → IDLE on the next edge. This has priority over all other transitions.
- Fault path:
  - fault_in passes through a 2-flop synchroniser.
  - The synchronised value =1 sets fault_latched.
  - fault_clr=1 with the synchronised fault =0 clears it.
  - Set wins over clear in the same cycle.
- After a fault is cleared, each enabled channel restarts through DEAD. It never goes directly to an ON state.

## Timing
- Reset: all FSMs go to IDLE.
  - gate_hi, gate_lo and ch_dead = 0.
  - fault_latched = 0.
  - Synchroniser flops = 0.
- Reset mid-DEAD or mid-ON: gates drop asynchronously, with no dead-time sequencing.
- pwm_in toggle sampled at edge k:
  - The active gate falls after edge k (1-cycle latency).
  - The opposite gate rises after edge k+max(deadtime,1).
- fault_in rise to fault_latched=1 takes 2 to 3 edges. All gates are 0 one edge after fault_latched rises.
- enable deasserted at edge k: gates are 0 after edge k.
- A PWM pulse shorter than the dead-time never turns on the opposite gate. The output is whatever pwm_in holds at DEAD exit.
- Counters are DT_WIDTH wide, count down only, and never wrap, because exit happens at 1.

## Structure
- Package fet_gate_pkg holds:
  - the state enum (IDLE, DEAD, HI_ON, LO_ON)
  - the default DT_WIDTH
  - CHANNELS
- Sub-module fet_gate_channel holds one FSM plus its dead-time counter and target register. It is instantiated CHANNELS times with a generate loop.
- The top level holds the fault synchroniser, the fault latch and the port fan-out.

## Test plan
- Reset, then enable=4'b0001, pwm_in=0, deadtime=5:
  - ch0 shows ch_dead for 5 cycles.
  - gate_lo[0]=1 follows; gate_hi stays 0.
- Steady state with deadtime=3, pwm_in[1] toggled 0→1:
  - gate_lo[1] falls one edge later.
  - gate_hi[1] rises 3 edges after that.
  - Assert !(gate_hi & gate_lo) on every cycle, for all channels.
- deadtime=0, pwm_in[2] toggles every 4 cycles:
  - Exactly one both-off cycle on each transition.
- deadtime=10, 2-cycle pwm_in pulse 0→1→0 starting in LO_ON:
  - gate_hi never rises.
  - gate_lo returns after 10 dead cycles.
- fault_in pulsed while all 4 channels run:
  - fault_latched rises within 3 edges, then all gates are 0.
  - fault_clr while fault_in is still high leaves the latch set.
  - After fault_in falls, fault_clr clears the latch and channels restart via DEAD.
- wb_rst_ni asserted while ch3 is in HI_ON mid-sequence:
  - Gates are 0 immediately.
  - After release, all outputs stay 0 until enable is applied.
